// File: rtl/cpu_pkg.sv
// Shared types and default widths for the operand-fetch slice.
package cpu_pkg;

   localparam int N_DEF   = 32;
   localparam int M_DEF   = 2;
   localparam int OPW_DEF = 4;

   typedef enum logic [1:0] {OF_EMPTY, OF_READ, OF_VALID} of_state_t;

endpackage

// File: rtl/operand_forward.sv
// Merges one masked writeback into an operand when the writeback targets that operand's register.
module operand_forward #(
   parameter int N = 32,
   parameter int M = 2
) (
   input  logic [N-1:0] x,
   input  logic [M-1:0] rs,
   input  logic         wb_valid,
   input  logic [M-1:0] wb_reg,
   input  logic [N-1:0] wb_mask,
   input  logic [N-1:0] wb_data,
   output logic [N-1:0] y
);

   function automatic logic [N-1:0] merge(input logic [N-1:0] old_v,
                                          input logic [N-1:0] mask,
                                          input logic [N-1:0] data);
      return (old_v & ~mask) | (data & mask);
   endfunction

   assign y = (wb_valid && (wb_reg == rs)) ? merge(x, wb_mask, wb_data) : x;

endmodule

// File: rtl/operand_fetch.sv
// Single-slot issue stage: reads the register file, forwards in-flight writebacks, hands operands to execute.
module operand_fetch
   import cpu_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int M   = M_DEF,
   parameter int OPW = OPW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [M-1:0]   in_rs1,
   input  logic [M-1:0]   in_rs2,
   input  logic [M-1:0]   in_rd,
   input  logic [OPW-1:0] in_op,
   output logic [M-1:0]   rf_r1,
   output logic [M-1:0]   rf_r2,
   input  logic [N-1:0]   rf_v1,
   input  logic [N-1:0]   rf_v2,
   input  logic           wb_valid,
   input  logic [M-1:0]   wb_reg,
   input  logic [N-1:0]   wb_mask,
   input  logic [N-1:0]   wb_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_a,
   output logic [N-1:0]   out_b,
   output logic [M-1:0]   out_rd,
   output logic [OPW-1:0] out_op
);

   of_state_t      state_q;
   logic [M-1:0]   rs1_p0, rs2_p0, rd_p0;
   logic [OPW-1:0] op_p0;
   logic           pend_vld_p0;
   logic [M-1:0]   pend_reg_p0;
   logic [N-1:0]   pend_mask_p0, pend_data_p0;
   logic [N-1:0]   opa_p1, opb_p1;
   logic [N-1:0]   pend_a, pend_b, base_a, base_b, cur_a, cur_b;
   logic           accept;

   assign in_ready  = !rst && !flush &&
                      ((state_q == OF_EMPTY) || ((state_q == OF_VALID) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = !rst && !flush && (state_q == OF_VALID);

   assign rf_r1 = rst ? '0 : (accept ? in_rs1 : rs1_p0);
   assign rf_r2 = rst ? '0 : (accept ? in_rs2 : rs2_p0);

   // The read data misses the write committed at the accept edge, so replay it first.
   operand_forward #(.N(N), .M(M)) u_pend_a (
      .x(rf_v1), .rs(rs1_p0), .wb_valid(pend_vld_p0), .wb_reg(pend_reg_p0),
      .wb_mask(pend_mask_p0), .wb_data(pend_data_p0), .y(pend_a));
   operand_forward #(.N(N), .M(M)) u_pend_b (
      .x(rf_v2), .rs(rs2_p0), .wb_valid(pend_vld_p0), .wb_reg(pend_reg_p0),
      .wb_mask(pend_mask_p0), .wb_data(pend_data_p0), .y(pend_b));

   assign base_a = (state_q == OF_READ) ? pend_a : opa_p1;
   assign base_b = (state_q == OF_READ) ? pend_b : opb_p1;

   operand_forward #(.N(N), .M(M)) u_cur_a (
      .x(base_a), .rs(rs1_p0), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_mask(wb_mask), .wb_data(wb_data), .y(cur_a));
   operand_forward #(.N(N), .M(M)) u_cur_b (
      .x(base_b), .rs(rs2_p0), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_mask(wb_mask), .wb_data(wb_data), .y(cur_b));

   assign out_a  = rst ? '0 : ((state_q == OF_VALID) ? cur_a : opa_p1);
   assign out_b  = rst ? '0 : ((state_q == OF_VALID) ? cur_b : opb_p1);
   assign out_rd = rd_p0;
   assign out_op = op_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= OF_EMPTY;
         rs1_p0       <= '0;
         rs2_p0       <= '0;
         rd_p0        <= '0;
         op_p0        <= '0;
         pend_vld_p0  <= 1'b0;
         pend_reg_p0  <= '0;
         pend_mask_p0 <= '0;
         pend_data_p0 <= '0;
         opa_p1       <= '0;
         opb_p1       <= '0;
      end else begin
         // stage p0: id latch and one-cycle-old writeback copy
         pend_vld_p0  <= wb_valid;
         pend_reg_p0  <= wb_reg;
         pend_mask_p0 <= wb_mask;
         pend_data_p0 <= wb_data;
         if (accept) begin
            rs1_p0 <= in_rs1;
            rs2_p0 <= in_rs2;
            rd_p0  <= in_rd;
            op_p0  <= in_op;
         end
         // stage p1: operands keep absorbing writebacks while held
         if (state_q != OF_EMPTY) begin
            opa_p1 <= cur_a;
            opb_p1 <= cur_b;
         end
         if (flush) begin
            state_q <= OF_EMPTY;
         end else begin
            case (state_q)
               OF_EMPTY: if (accept) state_q <= OF_READ;
               OF_READ:  state_q <= OF_VALID;
               OF_VALID: if (out_ready) state_q <= accept ? OF_READ : OF_EMPTY;
               default:  state_q <= OF_EMPTY;
            endcase
         end
      end
   end

endmodule
